// File: rtl/seven_segment_scan_ctrl.sv
// Scans NUM_DIGITS nibbles onto one shared seven-segment decoder.
// Each digit slot starts with a blanking gap, then shows the digit on its anode.
// Digit values arrive through a one-deep valid/ready write buffer. A buffered
// write is committed only while the scan is blanked, so a digit never changes
// while it is lit.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   en               1 = scan runs; 0 = scan position frozen, anodes off
//   load_valid/ready write handshake for one digit
//   load_digit       digit index (an out-of-range index is accepted, then dropped)
//   load_value       nibble for that digit
//   load_dp          decimal point for that digit
//   w,x,y,z,dp       decoder inputs (w = MSB)
//   an               active-low digit anodes, an[i] = digit i
module seven_segment_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 16,
  parameter int unsigned BLANK_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [$clog2(NUM_DIGITS)-1:0] load_digit,
  input  logic [3:0]                    load_value,
  input  logic                          load_dp,
  output logic                          w,
  output logic                          x,
  output logic                          y,
  output logic                          z,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         an
);

  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned CW = $clog2(REFRESH_DIV);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t                       state, state_next;
  logic [IW-1:0]                idx, idx_next;
  logic [CW-1:0]                slot_cnt, slot_next;
  logic [NUM_DIGITS-1:0][3:0]   digit_val;
  logic [NUM_DIGITS-1:0]        digit_dp;
  logic                         pending;
  logic [IW-1:0]                pend_digit;
  logic [3:0]                   pend_value;
  logic                         pend_dp;
  logic [3:0]                   nib;
  logic                         xfer;
  logic                         commit;

  // Scan position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_BLANK;
      idx      <= '0;
      slot_cnt <= '0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      slot_cnt <= slot_next;
    end
  end

  // Next scan position; everything holds while en is low.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    slot_next  = slot_cnt;
    if (en) begin
      case (state)
        ST_BLANK: begin
          slot_next = slot_cnt + CW'(1);
          if (slot_cnt == CW'(BLANK_CYCLES - 1)) state_next = ST_SHOW;
        end
        ST_SHOW: begin
          if (slot_cnt == CW'(REFRESH_DIV - 1)) begin
            state_next = ST_BLANK;
            slot_next  = '0;
            idx_next   = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
          end else begin
            slot_next = slot_cnt + CW'(1);
          end
        end
        default: state_next = ST_BLANK;
      endcase
    end
  end

  assign xfer   = load_valid & ~pending;
  assign commit = pending & (state == ST_BLANK);

  // Write buffer and display registers; commit happens only during blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      pend_digit <= '0;
      pend_value <= '0;
      pend_dp    <= 1'b0;
      digit_val  <= '0;
      digit_dp   <= '0;
    end else if (commit) begin
      pending <= 1'b0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (pend_digit == IW'(i)) begin
          digit_val[i] <= pend_value;
          digit_dp[i]  <= pend_dp;
        end
      end
    end else if (xfer) begin
      pending    <= 1'b1;
      pend_digit <= load_digit;
      pend_value <= load_value;
      pend_dp    <= load_dp;
    end
  end

  // Output decode; nibble and dp keep the shown digit while en is low.
  always_comb begin
    an  = '1;
    nib = '0;
    dp  = 1'b0;
    if (state == ST_SHOW) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (idx == IW'(i)) begin
          nib = digit_val[i];
          dp  = digit_dp[i];
          if (en) an[i] = 1'b0;
        end
      end
    end
  end

  assign {w, x, y, z} = nib;
  assign load_ready   = ~pending;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Directed bench: u0 uses the default parameters; u1 has 3 digits,
// REFRESH_DIV=6 and BLANK_CYCLES=2 for the out-of-range write and the longer blank.
module tb_seven_segment_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  // u0
  logic       en0, lv0, lr0, ldp0, w0, x0, y0, z0, dp0;
  logic [1:0] ld0;
  logic [3:0] lval0, an0;
  // u1
  logic       en1, lv1, lr1, ldp1, w1, x1, y1, z1, dp1;
  logic [1:0] ld1;
  logic [3:0] lval1;
  logic [2:0] an1;

  int cyc;
  int n_cmp;
  int n_bad;

  always #5 clk = ~clk;

  seven_segment_scan_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .load_valid(lv0), .load_ready(lr0),
    .load_digit(ld0), .load_value(lval0), .load_dp(ldp0),
    .w(w0), .x(x0), .y(y0), .z(z0), .dp(dp0), .an(an0)
  );

  seven_segment_scan_ctrl #(.NUM_DIGITS(3), .REFRESH_DIV(6), .BLANK_CYCLES(2)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .load_valid(lv1), .load_ready(lr1),
    .load_digit(ld1), .load_value(lval1), .load_dp(ldp1),
    .w(w1), .x(x1), .y(y1), .z(z1), .dp(dp1), .an(an1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic goto(input int c);
    if (c > cyc) tick(c - cyc);
  endtask

  task automatic chk0(input string tag, input logic [3:0] an_e, input logic [3:0] nib_e,
                      input logic dp_e);
    check_eq({tag, "_an"},  32'(an0), 32'(an_e));
    check_eq({tag, "_nib"}, 32'({w0, x0, y0, z0}), 32'(nib_e));
    check_eq({tag, "_dp"},  32'(dp0), 32'(dp_e));
  endtask

  task automatic chk1(input string tag, input logic [2:0] an_e, input logic [3:0] nib_e,
                      input logic dp_e);
    check_eq({tag, "_an"},  32'(an1), 32'(an_e));
    check_eq({tag, "_nib"}, 32'({w1, x1, y1, z1}), 32'(nib_e));
    check_eq({tag, "_dp"},  32'(dp1), 32'(dp_e));
  endtask

  initial begin
    logic [3:0] vals [4];
    logic       dps  [4];
    int         xfer_cyc [4];
    int         n;
    vals = '{4'h3, 4'hC, 4'h5, 4'hF};
    dps  = '{1'b0, 1'b1, 1'b0, 1'b1};
    xfer_cyc = '{113, 129, 145, 161};
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst_n = 1'b0;
    en0 = 1'b1; lv0 = 1'b0; ld0 = '0; lval0 = '0; ldp0 = 1'b0;
    en1 = 1'b1; lv1 = 1'b0; ld1 = '0; lval1 = '0; ldp1 = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk0("rst0", 4'b1111, 4'h0, 1'b0);
    check_eq("rst0_ready", 32'(lr0), 32'd1);
    chk1("rst1", 3'b111, 4'h0, 1'b0);
    rst_n = 1'b1;
    cyc = 0;

    // basic scan timing
    chk0("c0", 4'b1111, 4'h0, 1'b0);
    chk1("u1_c0", 3'b111, 4'h0, 1'b0);
    goto(1);  chk0("c1", 4'b1110, 4'h0, 1'b0);
    check_eq("u1_c1_an", 32'(an1), 32'(3'b111));
    goto(2);  check_eq("u1_c2_an", 32'(an1), 32'(3'b110));
    goto(6);  check_eq("u1_c6_an", 32'(an1), 32'(3'b111));
    goto(8);  check_eq("u1_c8_an", 32'(an1), 32'(3'b101));
    goto(15); check_eq("c15_an", 32'(an0), 32'(4'b1110));
    goto(16); check_eq("c16_an", 32'(an0), 32'(4'b1111));
    goto(17); check_eq("c17_an", 32'(an0), 32'(4'b1101));

    // u1: valid write, then out-of-range digit 3 accepted and dropped
    goto(20);
    lv1 = 1'b1; ld1 = 2'd1; lval1 = 4'h6; ldp1 = 1'b1;
    check_eq("u1_w1_ready", 32'(lr1), 32'd1);
    tick(1); lv1 = 1'b0;
    check_eq("u1_w1_busy", 32'(lr1), 32'd0);
    goto(24); check_eq("u1_w1_busy_blank", 32'(lr1), 32'd0);
    goto(25); check_eq("u1_w1_done", 32'(lr1), 32'd1);
    lv1 = 1'b1; ld1 = 2'd3; lval1 = 4'h7; ldp1 = 1'b1;
    tick(1); lv1 = 1'b0;
    check_eq("u1_w3_busy", 32'(lr1), 32'd0);
    chk1("u1_show1", 3'b101, 4'h6, 1'b1);
    goto(31);
    check_eq("c31_an", 32'(an0), 32'(4'b1101));
    check_eq("u1_w3_done", 32'(lr1), 32'd1);
    goto(32); chk1("u1_show2", 3'b011, 4'h0, 1'b0);
    goto(40); chk1("u1_show0", 3'b110, 4'h0, 1'b0);
    goto(44); chk1("u1_show1b", 3'b101, 4'h6, 1'b1);

    // frame wrap, then single write to digit 2 during digit 0
    goto(65);
    check_eq("c65_an", 32'(an0), 32'(4'b1110));
    lv0 = 1'b1; ld0 = 2'd2; lval0 = 4'hA; ldp0 = 1'b1;
    check_eq("t2_ready", 32'(lr0), 32'd1);
    tick(1); lv0 = 1'b0;
    check_eq("t2_busy", 32'(lr0), 32'd0);
    goto(79); check_eq("t2_busy79", 32'(lr0), 32'd0);
    goto(80); check_eq("t2_busy80", 32'(lr0), 32'd0);
    goto(81); check_eq("t2_done", 32'(lr0), 32'd1);
    chk0("t2_d1", 4'b1101, 4'h0, 1'b0);
    goto(100); chk0("t2_d2", 4'b1011, 4'hA, 1'b1);

    // back-to-back writes, valid held high
    goto(113);
    lv0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ld0 = 2'(k); lval0 = vals[k]; ldp0 = dps[k];
      n = 0;
      while (!lr0 && n < 40) begin tick(1); n++; end
      check_eq($sformatf("t3_ready%0d", k), 32'(lr0), 32'd1);
      check_eq($sformatf("t3_xfer%0d", k), 32'(cyc), 32'(xfer_cyc[k]));
      tick(1);
    end
    lv0 = 1'b0;
    goto(200); chk0("t3_d0", 4'b1110, 4'h3, 1'b0);
    goto(216); chk0("t3_d1", 4'b1101, 4'hC, 1'b1);
    goto(232); chk0("t3_d2", 4'b1011, 4'h5, 1'b0);
    goto(248); chk0("t3_d3", 4'b0111, 4'hF, 1'b1);

    // enable freeze during digit 1
    goto(275);
    en0 = 1'b0; #1;
    chk0("t5_off", 4'b1111, 4'hC, 1'b1);
    goto(284); chk0("t5_off9", 4'b1111, 4'hC, 1'b1);
    goto(285); en0 = 1'b1; #1;
    chk0("t5_on", 4'b1101, 4'hC, 1'b1);
    goto(297); check_eq("t5_last", 32'(an0), 32'(4'b1101));
    goto(298); check_eq("t5_blank", 32'(an0), 32'(4'b1111));
    goto(299); chk0("t5_next", 4'b1011, 4'h5, 1'b0);

    // reset mid-frame with a pending write
    goto(300);
    lv0 = 1'b1; ld0 = 2'd1; lval0 = 4'h9; ldp0 = 1'b0;
    tick(1); lv0 = 1'b0;
    check_eq("t6_busy", 32'(lr0), 32'd0);
    goto(305);
    rst_n = 1'b0; #1;
    chk0("t6_rst", 4'b1111, 4'h0, 1'b0);
    check_eq("t6_rst_ready", 32'(lr0), 32'd1);
    tick(2);
    rst_n = 1'b1;
    cyc = 0;
    chk0("t6_c0", 4'b1111, 4'h0, 1'b0);
    goto(1);  chk0("t6_c1", 4'b1110, 4'h0, 1'b0);
    goto(8);  chk1("t6_u1_c8", 3'b101, 4'h0, 1'b0);
    goto(17); chk0("t6_c17", 4'b1101, 4'h0, 1'b0);
    check_eq("t6_ready", 32'(lr0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
